// File: rtl/ibuff_fill_if.sv
// ibuff_fill_if: valid/ready fetch request channel plus in-order response channel
// between the instruction buffer (master) and the I-cache (slave).
//   fetch_req_valid/ready/addr   : 16-byte chunk request
//   fetch_rsp_valid/data/exception : chunk response, returned in request order
interface ibuff_fill_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            fetch_req_valid;
    logic            fetch_req_ready;
    logic [XLEN-1:0] fetch_req_addr;
    logic            fetch_rsp_valid;
    logic [127:0]    fetch_rsp_data;
    logic            fetch_rsp_exception;

    modport master (
        output fetch_req_valid,
        output fetch_req_addr,
        input  fetch_req_ready,
        input  fetch_rsp_valid,
        input  fetch_rsp_data,
        input  fetch_rsp_exception
    );

    modport slave (
        input  fetch_req_valid,
        input  fetch_req_addr,
        output fetch_req_ready,
        output fetch_rsp_valid,
        output fetch_rsp_data,
        output fetch_rsp_exception
    );
endinterface

// File: rtl/ibuff_fill.sv
// ibuff_fill: instruction buffer feeding D1. Holds one 64-byte line as four
// 16-byte chunks, fetches them from the I-cache, advances the PC as D1 consumes
// instructions and flushes/refetches on resteer or line crossing.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   resteer(_target)    : flush and redirect (bit 0 of target ignored)
//   advance(_compressed): D1 consumed a 2- or 4-byte instruction at pc_out
//   fetch               : request/response channel to the I-cache (master side)
//   IBuff_out           : 512-bit line, chunk c at bits [128c+127:128c]
//   IBuff_valid_out     : bit 3-c = chunk c valid
//   pc_out              : current PC
//   exception_out       : chunk of pc_out is valid and faulted
// Optional: define IBUFF_PERF_CNT_EN to add perf_stall_cycles, a saturating
// count of cycles where the chunk holding pc_out is not valid.
module ibuff_fill #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            resteer,
    input  logic [XLEN-1:0] resteer_target,
    input  logic            advance,
    input  logic            advance_compressed,
    ibuff_fill_if.master    fetch,
    output logic [511:0]    IBuff_out,
    output logic [3:0]      IBuff_valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic            exception_out
`ifdef IBUFF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [1:0]          req_chunk_q, req_chunk_d;
    logic [1:0]          fill_chunk_q, fill_chunk_d;
    logic [1:0]          start_chunk_q, start_chunk_d;
    logic [3:0]          valid_q, valid_d;
    logic [3:0]          exc_q, exc_d;
    logic [3:0][127:0]   data_q, data_d;
    logic [CNT_W-1:0]    out_q, out_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic                req_valid_q, req_valid_d;
    logic [XLEN-1:0]     req_addr_q, req_addr_d;
    logic                exc_out_q, exc_out_d;

    logic                hs;
    logic                rsp_drop;
    logic                rsp_accept;
    logic                do_flush;
    logic [XLEN-1:0]     flush_pc;
    logic [XLEN-1:0]     pc_adv;
    logic [3:0]          start_mask;

    // Next-state: fill, FSM, advance, flush; registered outputs derived from next state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_chunk_d   = req_chunk_q;
        fill_chunk_d  = fill_chunk_q;
        start_chunk_d = start_chunk_q;
        valid_d       = valid_q;
        exc_d         = exc_q;
        data_d        = data_q;
        drop_d        = drop_q;
        do_flush      = 1'b0;
        flush_pc      = pc_q;

        hs         = req_valid_q & fetch.fetch_req_ready;
        rsp_drop   = fetch.fetch_rsp_valid & (drop_q != '0);
        rsp_accept = fetch.fetch_rsp_valid & (drop_q == '0);
        pc_adv     = pc_q + (advance_compressed ? XLEN'(2) : XLEN'(4));
        start_mask = 4'(4'hF << start_chunk_q);
        out_d      = out_q + CNT_W'(hs) - CNT_W'(fetch.fetch_rsp_valid);

        if (rsp_drop) begin
            drop_d = drop_q - CNT_W'(1);
        end

        // Responses are in order, so the next accepted one is always fill_chunk.
        if (rsp_accept) begin
            data_d[fill_chunk_q]  = fetch.fetch_rsp_data;
            valid_d[fill_chunk_q] = 1'b1;
            exc_d[fill_chunk_q]   = fetch.fetch_rsp_exception;
            fill_chunk_d          = fill_chunk_q + 2'd1;
        end

        case (state_q)
            S_FILL: begin
                if (hs) begin
                    req_chunk_d = req_chunk_q + 2'd1;
                    if (req_chunk_q == 2'd3) begin
                        state_d = S_WAIT;
                    end
                end
                if (rsp_accept && fetch.fetch_rsp_exception) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A faulted line is complete once everything in flight has returned.
                if (((valid_q & start_mask) == start_mask) ||
                    ((exc_q != '0) && (out_q == '0))) begin
                    state_d = S_FULL;
                end
            end
            default: ;
        endcase

        if (resteer) begin
            do_flush = 1'b1;
            flush_pc = resteer_target & ~XLEN'(1);
        end else if (advance && valid_q[pc_q[5:4]]) begin
            pc_d = pc_adv;
            if (pc_adv[XLEN-1:6] != pc_q[XLEN-1:6]) begin
                do_flush = 1'b1;
                flush_pc = pc_adv;
            end
        end

        // Flush discards this cycle's response; everything still in flight is dropped.
        if (do_flush) begin
            pc_d          = flush_pc;
            valid_d       = '0;
            exc_d         = '0;
            req_chunk_d   = flush_pc[5:4];
            fill_chunk_d  = flush_pc[5:4];
            start_chunk_d = flush_pc[5:4];
            drop_d        = out_d;
            state_d       = S_FILL;
        end

        req_valid_d = (state_d == S_FILL) && (out_d < CNT_W'(MAX_OUTSTANDING));
        req_addr_d  = {pc_d[XLEN-1:6], req_chunk_d, 4'b0000};
        exc_out_d   = valid_d[pc_d[5:4]] & exc_d[pc_d[5:4]];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FILL;
            pc_q          <= RESET_PC;
            req_chunk_q   <= RESET_PC[5:4];
            fill_chunk_q  <= RESET_PC[5:4];
            start_chunk_q <= RESET_PC[5:4];
            valid_q       <= '0;
            exc_q         <= '0;
            data_q        <= '0;
            out_q         <= '0;
            drop_q        <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= {RESET_PC[XLEN-1:4], 4'b0000};
            exc_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_chunk_q   <= req_chunk_d;
            fill_chunk_q  <= fill_chunk_d;
            start_chunk_q <= start_chunk_d;
            valid_q       <= valid_d;
            exc_q         <= exc_d;
            data_q        <= data_d;
            out_q         <= out_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            exc_out_q     <= exc_out_d;
        end
    end

    assign fetch.fetch_req_valid = req_valid_q;
    assign fetch.fetch_req_addr  = req_addr_q;
    assign IBuff_out             = data_q;
    assign IBuff_valid_out       = {valid_q[0], valid_q[1], valid_q[2], valid_q[3]};
    assign pc_out                = pc_q;
    assign exception_out         = exc_out_q;

`ifdef IBUFF_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating stall counter: chunk under pc_out not yet available.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (!valid_q[pc_q[5:4]] && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_ibuff_fill.sv
// tb_ibuff_fill: randomized bench acting as the I-cache. The reference model
// tags each request with a flush generation; a response is kept only if its
// generation is current and no flush happens in that cycle.
module tb_ibuff_fill;

    localparam int unsigned   XLEN     = 32;
    localparam logic [31:0]   RESET_PC = 32'h0000_0000;
    localparam int unsigned   MAX_OUT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        resteer;
    logic [31:0] resteer_target;
    logic        advance;
    logic        advance_compressed;
    logic [511:0] IBuff_out;
    logic [3:0]  IBuff_valid_out;
    logic [31:0] pc_out;
    logic        exception_out;
`ifdef IBUFF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
`endif

    ibuff_fill_if #(.XLEN(XLEN)) bus ();

    ibuff_fill #(
        .XLEN            (XLEN),
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .resteer            (resteer),
        .resteer_target     (resteer_target),
        .advance            (advance),
        .advance_compressed (advance_compressed),
        .fetch              (bus),
        .IBuff_out          (IBuff_out),
        .IBuff_valid_out    (IBuff_valid_out),
        .pc_out             (pc_out),
        .exception_out      (exception_out)
`ifdef IBUFF_PERF_CNT_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gen;
    } req_t;

    req_t         q[$];
    logic [31:0]  m_pc;
    logic [3:0]   m_valid;
    logic [3:0]   m_exc;
    logic [127:0] m_data [4];
    int           m_next_chunk;
    bit           m_fault;
    int           gen = 0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        gen++;
        m_pc         = RESET_PC;
        m_valid      = '0;
        m_exc        = '0;
        m_fault      = 1'b0;
        m_next_chunk = int'(RESET_PC[5:4]);
        for (int i = 0; i < 4; i++) m_data[i] = '0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom % 4)
            0:       t = $urandom;
            1:       t = $urandom % 256;
            2:       t = 32'hFFFF_FFC0 + ($urandom % 64);
            default: t = ($urandom & 32'hFFFF_FFC0) | (32'd56 + ($urandom % 8));
        endcase
        return t;
    endfunction

    // Compare every visible output against the model (model reflects the last edge).
    task automatic do_checks();
        int  c;
        bit  allowed;
        c = int'(m_pc[5:4]);
        chk_eq("pc", 512'(pc_out), 512'(m_pc));
        chk_eq("valid", 512'(IBuff_valid_out), 512'({m_valid[0], m_valid[1], m_valid[2], m_valid[3]}));
        chk_eq("exc", 512'(exception_out), 512'(m_valid[c] & m_exc[c]));
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k]) chk_eq($sformatf("data%0d", k), 512'(IBuff_out[128*k +: 128]), 512'(m_data[k]));
        end
        allowed = !m_fault && (m_next_chunk <= 3) && (q.size() < MAX_OUT);
        chk_eq("req_valid", 512'(bus.fetch_req_valid), 512'(allowed));
        if (bus.fetch_req_valid && allowed) begin
            chk_eq("req_addr", 512'(bus.fetch_req_addr), 512'({m_pc[31:6], 2'(m_next_chunk), 4'b0000}));
        end
    endtask

    task automatic model_update(input bit hs, input logic [31:0] a, input bit rv, input req_t it,
                                input logic [127:0] rd, input bit rx, input bit adv, input bit comp,
                                input bit rs, input logic [31:0] tgt);
        bit          flush;
        logic [31:0] npc;
        int          c;
        int          rc;
        flush = 1'b0;
        npc   = m_pc;
        c     = int'(m_pc[5:4]);
        if (rs) begin
            flush = 1'b1;
            npc   = {tgt[31:1], 1'b0};
        end else if (adv && m_valid[c]) begin
            npc   = m_pc + (comp ? 32'd2 : 32'd4);
            flush = (npc[31:6] != m_pc[31:6]);
        end
        if (hs) begin
            q.push_back('{a, gen});
            m_next_chunk++;
        end
        if (rv && !flush && (it.gen == gen)) begin
            rc          = int'(it.addr[5:4]);
            m_data[rc]  = rd;
            m_valid[rc] = 1'b1;
            m_exc[rc]   = rx;
            if (rx) m_fault = 1'b1;
        end
        if (flush) begin
            gen++;
            m_valid      = '0;
            m_exc        = '0;
            m_fault      = 1'b0;
            m_next_chunk = int'(npc[5:4]);
        end
        m_pc = npc;
    endtask

    // One cycle: check at negedge, drive random inputs, update model at posedge.
    task automatic step(input bit allow_ctl, input bit fast);
        bit           hs;
        bit           rv;
        bit           rx;
        req_t         it;
        logic [127:0] rd;
        logic [31:0]  a;
        do_checks();
        rv = (q.size() > 0) && (fast || ($urandom % 3 != 0));
        rx = 1'b0;
        rd = '0;
        it = '{32'd0, -1};
        if (rv) begin
            it = q.pop_front();
            rd = {$urandom, $urandom, $urandom, $urandom};
            rx = ($urandom % 16) == 0;
        end
        bus.fetch_rsp_valid     = rv;
        bus.fetch_rsp_data      = rd;
        bus.fetch_rsp_exception = rx;
        bus.fetch_req_ready     = fast || ($urandom % 4 != 0);
        hs = bus.fetch_req_valid && bus.fetch_req_ready;
        a  = bus.fetch_req_addr;
        advance            = allow_ctl && ($urandom % 2 == 0);
        advance_compressed = ($urandom % 2 == 0);
        resteer            = allow_ctl && ($urandom % 40 == 0);
        resteer_target     = pick_target();
        @(posedge clk);
        model_update(hs, a, rv, it, rd, rx, advance, advance_compressed, resteer, resteer_target);
        @(negedge clk);
    endtask

    // Reset DUT and cache side together, then check reset values.
    task automatic do_reset();
        rst                     = 1'b1;
        advance                 = 1'b0;
        advance_compressed      = 1'b0;
        resteer                 = 1'b0;
        resteer_target          = '0;
        bus.fetch_req_ready     = 1'b0;
        bus.fetch_rsp_valid     = 1'b0;
        bus.fetch_rsp_data      = '0;
        bus.fetch_rsp_exception = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        chk_eq("rst_pc", 512'(pc_out), 512'(RESET_PC));
        chk_eq("rst_valid", 512'(IBuff_valid_out), 512'(0));
        chk_eq("rst_exc", 512'(exception_out), 512'(0));
        chk_eq("rst_data", IBuff_out, 512'(0));
        chk_eq("rst_req_valid", 512'(bus.fetch_req_valid), 512'(0));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 1500; i++) step(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 1500; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
